// File: rtl/addr_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr_scan_pkg
// Description : Shared state encoding and pace-counter sizing for the
//               address scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package addr_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } scan_state_t;

    // A one-state divider still needs a one-bit counter to keep ports legal.
    function automatic int pace_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pace_divider.sv
`default_nettype none
// ============================================================================
// Module      : pace_divider
// Description : Modulo-DIV pace counter with enable, clear and a
//               combinational terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pace_divider
    import addr_scan_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic last
);

    localparam int             c_PW   = pace_width(DIV);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DIV - 1);

    logic [c_PW-1:0] r_pace;

    assign last = (r_pace == c_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pace <= '0;
        end else if (clr) begin
            r_pace <= '0;
        end else if (en) begin
            r_pace <= last ? '0 : r_pace + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/addr_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : addr_scan_ctrl
// Description : Paced 0..N address sweeper with pause/resume, single-step and
//               registered tick/wrap/done strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_scan_ctrl
    import addr_scan_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int N     = 31,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic             loop,
    output logic [WIDTH-1:0] addr,
    output logic             tick,
    output logic             wrap,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] c_N = WIDTH'(N);

    scan_state_t      r_state, w_state_nxt;
    logic [WIDTH-1:0] r_addr, w_addr_nxt, w_addr_inc;
    logic             r_tick, r_wrap, r_done;
    logic             w_tick_nxt, w_wrap_nxt, w_done_nxt;
    logic             w_pace_en, w_pace_clr, w_pace_last, w_at_n;

    pace_divider #(
        .DIV (DIV)
    ) u_pace (
        .clk   (clk),
        .reset (reset),
        .en    (w_pace_en),
        .clr   (w_pace_clr),
        .last  (w_pace_last)
    );

    // Wrap is explicit so N == 2**WIDTH-1 behaves the same as any other N.
    assign w_at_n     = (r_addr == c_N);
    assign w_addr_inc = w_at_n ? '0 : r_addr + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_tick_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_pace_en   = 1'b0;
        w_pace_clr  = 1'b0;

        if (clear) begin
            w_state_nxt = S_IDLE;
            w_addr_nxt  = '0;
            w_pace_clr  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!pause) begin
                        if (start) begin
                            w_state_nxt = S_RUN;
                            w_addr_nxt  = '0;
                            w_pace_clr  = 1'b1;
                            w_tick_nxt  = (r_addr != '0);
                        end else if (step) begin
                            w_addr_nxt = w_addr_inc;
                            w_tick_nxt = 1'b1;
                            w_wrap_nxt = w_at_n;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSE;
                    end else begin
                        w_pace_en = 1'b1;
                        if (w_pace_last) begin
                            if (!w_at_n || loop) begin
                                w_addr_nxt = w_addr_inc;
                                w_tick_nxt = 1'b1;
                                w_wrap_nxt = w_at_n;
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        if (start) begin
                            w_state_nxt = S_RUN;
                        end else if (step) begin
                            w_addr_nxt = w_addr_inc;
                            w_pace_clr = 1'b1;
                            w_tick_nxt = 1'b1;
                            w_wrap_nxt = w_at_n;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_tick  <= w_tick_nxt;
            r_wrap  <= w_wrap_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign addr = r_addr;
    assign tick = r_tick;
    assign wrap = r_wrap;
    assign done = r_done;
    assign busy = (r_state == S_RUN);

endmodule
`default_nettype wire
